// File: rtl/pc_gen_bp.sv
// Fetch PC generator with prioritised redirects (trap > EX redirect > stall >
// prediction > sequential) and a direct-mapped BTB with 2-bit counters.
module pc_gen_bp #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned     BTB_ENTRIES  = 16,
  parameter bit              BTB_EN       = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            keep_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            branch_op,
  input  logic [XLEN-1:0] branch_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  output logic [XLEN-1:0] pc_if,
  output logic [XLEN-1:0] pc4_if,
  output logic            pred_taken_if,
  output logic [XLEN-1:0] pred_target_if,
  output logic            misaligned_if
);

  localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
  localparam int unsigned TAGW = XLEN - IDX - 2;

  logic            btb_valid  [BTB_ENTRIES];
  logic [TAGW-1:0] btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0] btb_target [BTB_ENTRIES];
  logic [1:0]      btb_ctr    [BTB_ENTRIES];

  logic [IDX-1:0]  look_idx, upd_idx;
  logic [TAGW-1:0] look_tag, upd_tag;
  logic            look_hit, upd_hit;
  logic [XLEN-1:0] pc_next;
  logic            mis_next;
  logic            unused_upd_lsb;

  assign look_idx = pc_if[IDX+1:2];
  assign look_tag = pc_if[XLEN-1:IDX+2];
  assign upd_idx  = upd_pc[IDX+1:2];
  assign upd_tag  = upd_pc[XLEN-1:IDX+2];
  assign unused_upd_lsb = ^upd_pc[1:0];

  assign look_hit = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
  assign upd_hit  = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

  assign pred_taken_if  = BTB_EN && look_hit && btb_ctr[look_idx][1];
  assign pred_target_if = pred_taken_if ? btb_target[look_idx] : '0;
  assign pc4_if         = pc_if + XLEN'(4);

  // Redirect targets are word-aligned on load; the dropped low bits are
  // reported through misaligned_if, which only a stall may preserve.
  always_comb begin
    pc_next  = pc4_if;
    mis_next = 1'b0;
    if (trap_valid) begin
      pc_next  = {trap_target[XLEN-1:2], 2'b00};
      mis_next = |trap_target[1:0];
    end else if (branch_op) begin
      pc_next  = {branch_target[XLEN-1:2], 2'b00};
      mis_next = |branch_target[1:0];
    end else if (keep_pc) begin
      pc_next  = pc_if;
      mis_next = misaligned_if;
    end else if (pred_taken_if) begin
      pc_next  = pred_target_if;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_if         <= RESET_VECTOR;
      misaligned_if <= 1'b0;
    end else begin
      pc_if         <= pc_next;
      misaligned_if <= mis_next;
    end
  end

  // Lookup reads the pre-edge contents; updates are independent of PC control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'b01;
      end
    end else if (BTB_EN && upd_valid) begin
      if (upd_taken) begin
        if (upd_hit) begin
          btb_target[upd_idx] <= upd_target;
          if (btb_ctr[upd_idx] != 2'b11) btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'd1;
        end else begin
          btb_valid[upd_idx]  <= 1'b1;
          btb_tag[upd_idx]    <= upd_tag;
          btb_target[upd_idx] <= upd_target;
          btb_ctr[upd_idx]    <= 2'b10;
        end
      end else if (upd_hit && btb_ctr[upd_idx] != 2'b00) begin
        btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen_bp.sv
// Scoreboard bench for pc_gen_bp: directed plan plus random traffic against
// an integer-level BTB/PC reference model.
module tb_pc_gen_bp;

  localparam int unsigned N   = 16;
  localparam int unsigned IDX = $clog2(N);
  localparam logic [31:0] RV  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        keep_pc = 1'b0, trap_valid = 1'b0, branch_op = 1'b0;
  logic        upd_valid = 1'b0, upd_taken = 1'b0;
  logic [31:0] trap_target = '0, branch_target = '0, upd_pc = '0, upd_target = '0;
  logic [31:0] pc_if, pc4_if, pred_target_if;
  logic        pred_taken_if, misaligned_if;

  pc_gen_bp #(.XLEN(32), .RESET_VECTOR(RV), .BTB_ENTRIES(N), .BTB_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .keep_pc(keep_pc),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .branch_op(branch_op), .branch_target(branch_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .pc_if(pc_if), .pc4_if(pc4_if), .pred_taken_if(pred_taken_if),
    .pred_target_if(pred_target_if), .misaligned_if(misaligned_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          mis;
    bit          pt;
    logic [31:0] ptgt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // reference state
  logic [31:0] m_pc;
  bit          m_mis;
  bit          m_valid [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc  = RV;
    m_mis = 0;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    int unsigned i = (pc >> 2) % N;
    return m_valid[i] && (m_tag[i] == (pc >> (2 + IDX)));
  endfunction

  function automatic bit model_pred(input logic [31:0] pc);
    return model_hit(pc) && (m_ctr[(pc >> 2) % N] >= 2);
  endfunction

  // Drives one cycle of inputs (called at a negedge), advances the model,
  // queues the expected post-edge outputs and returns at the next negedge.
  task automatic drv(input bit tv, input logic [31:0] tt, input bit bo, input logic [31:0] bt,
                     input bit kp, input bit uv, input logic [31:0] up,
                     input logic [31:0] utg, input bit tk);
    logic [31:0] npc;
    bit          nmis;
    int unsigned ui;
    exp_t        e;
    trap_valid = tv; trap_target = tt; branch_op = bo; branch_target = bt;
    keep_pc = kp; upd_valid = uv; upd_pc = up; upd_target = utg; upd_taken = tk;
    if (tv) begin
      npc = tt & ~32'd3; nmis = (tt % 4) != 0;
    end else if (bo) begin
      npc = bt & ~32'd3; nmis = (bt % 4) != 0;
    end else if (kp) begin
      npc = m_pc; nmis = m_mis;
    end else if (model_pred(m_pc)) begin
      npc = m_tgt[(m_pc >> 2) % N]; nmis = 0;
    end else begin
      npc = m_pc + 32'd4; nmis = 0;
    end
    if (uv) begin
      ui = (up >> 2) % N;
      if (tk) begin
        if (model_hit(up)) begin
          m_tgt[ui] = utg;
          if (m_ctr[ui] < 3) m_ctr[ui]++;
        end else begin
          m_valid[ui] = 1; m_tag[ui] = up >> (2 + IDX); m_tgt[ui] = utg; m_ctr[ui] = 2;
        end
      end else if (model_hit(up) && m_ctr[ui] > 0) begin
        m_ctr[ui]--;
      end
    end
    m_pc  = npc;
    m_mis = nmis;
    e.pc   = m_pc;
    e.mis  = m_mis;
    e.pt   = model_pred(m_pc);
    e.ptgt = e.pt ? m_tgt[(m_pc >> 2) % N] : 32'd0;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic br(input logic [31:0] t);
    drv(0, 0, 1, t, 0, 0, 0, 0, 0);
  endtask

  // monitor: one expected record per clock edge while traffic is flowing
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc_if", pc_if, e.pc);
      chk("pc4_if", pc4_if, e.pc + 32'd4);
      chk("misaligned_if", {31'd0, misaligned_if}, {31'd0, e.mis});
      chk("pred_taken_if", {31'd0, pred_taken_if}, {31'd0, e.pt});
      chk("pred_target_if", pred_target_if, e.ptgt);
    end
  end

  initial begin
    bit          tv, bo, kp, uv, tk;
    logic [31:0] tt, bt, up, utg;
    int          r;

    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_pc", pc_if, RV);
    chk("reset_pc4", pc4_if, RV + 32'd4);
    chk("reset_mis", {31'd0, misaligned_if}, 32'd0);
    chk("reset_pred", {31'd0, pred_taken_if}, 32'd0);
    rst_n = 1'b1;

    // sequential, redirect-over-stall, trap priority, misalignment
    repeat (3) idle();
    drv(0, 0, 1, 32'h100, 1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1, 0, 0, 0, 0);
    drv(1, 32'h200, 1, 32'h300, 0, 0, 0, 0, 0);
    br(32'h302);
    drv(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle();

    // BTB allocate, predict, alias, train down
    drv(0, 0, 0, 0, 0, 1, 32'h40, 32'h80, 1);
    br(32'h40);
    idle();
    br(32'h40 + 4 * N);
    idle();
    drv(0, 0, 0, 0, 0, 1, 32'h40, 32'h80, 0);
    drv(0, 0, 0, 0, 0, 1, 32'h40, 32'h80, 0);
    br(32'h40);
    idle();

    // wrap at top of address space
    br(32'hFFFF_FFFC);
    idle();
    idle();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      r   = $urandom_range(0, 99);
      tv  = (r < 4);
      bo  = (r >= 4 && r < 16);
      kp  = ($urandom_range(0, 5) == 0);
      tt  = $urandom_range(0, 1023);
      bt  = $urandom_range(0, 1023);
      uv  = ($urandom_range(0, 2) == 0);
      tk  = ($urandom_range(0, 3) != 0);
      utg = $urandom_range(0, 1023) & ~32'd3;
      case ($urandom_range(0, 2))
        0:       up = m_pc;
        1:       up = $urandom_range(0, 255) << 2;
        default: up = m_pc + 4 * N;
      endcase
      drv(tv, tt, bo, bt, kp, uv, up, utg, tk);
    end

    // train 0x40 taken, confirm prediction, then reset between edges
    drv(0, 0, 0, 0, 0, 1, 32'h40, 32'h120, 1);
    br(32'h40);
    trap_valid = 0; branch_op = 0; keep_pc = 0; upd_valid = 0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_pc", pc_if, RV);
    chk("async_reset_mis", {31'd0, misaligned_if}, 32'd0);
    chk("async_reset_pred", {31'd0, pred_taken_if}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    br(32'h40);
    idle();
    idle();

    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
